// File: rtl/niossys_mycpu_cpu_mult_seq_if.sv
// Start/busy/done request bus between the execute-stage stall logic (master)
// and the sequential multiplier (slave).
interface niossys_mycpu_cpu_mult_seq_if;
  logic        A_start;
  logic [1:0]  A_op;
  logic [31:0] A_src1;
  logic [31:0] A_src2;
  logic        A_busy;
  logic        A_done;
  logic [31:0] A_result;

  modport master (
    output A_start, A_op, A_src1, A_src2,
    input  A_busy, A_done, A_result
  );

  modport slave (
    input  A_start, A_op, A_src1, A_src2,
    output A_busy, A_done, A_result
  );
endinterface

// File: rtl/niossys_mycpu_cpu_mult_seq.sv
// Sequential 32x32 multiplier built on one pipelined 16x16 unsigned multiplier.
// Define MULT_SEQ_SIGNED_EN to enable the signed-correction step for mulxss/mulxsu.
module niossys_mycpu_cpu_mult_seq (
  input  logic                               clk,
  input  logic                               reset_n,
  niossys_mycpu_cpu_mult_seq_if.slave        bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_CORR,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [1:0]  op_q;
  logic [31:0] src1_q, src2_q;

  logic [15:0] mul_a_q, mul_b_q;
  logic [1:0]  tag1_q, tag2_q;
  logic        iss_v_q, prod_v_q;
  logic [31:0] prod_q;

  logic [63:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;

  logic        capture;
  logic        need_corr;
  logic [1:0]  last_k;
  logic        mult_en;
  logic [15:0] a_sel, b_sel;
  logic [1:0]  tag_sel;

  // Low-word multiply never needs a_hi*b_hi since it only lands above bit 31.
  assign last_k  = (op_q == 2'b00) ? 2'd2 : 2'd3;
  assign mult_en = (state_q == S_ISSUE) || (state_q == S_DRAIN);

`ifdef MULT_SEQ_SIGNED_EN
  assign need_corr = (op_q == 2'b01) || (op_q == 2'b10);
`else
  assign need_corr = 1'b0;
`endif

  // k[1] picks the high half of src1, k[0] the high half of src2.
  assign a_sel   = k_q[1] ? src1_q[31:16] : src1_q[15:0];
  assign b_sel   = k_q[0] ? src2_q[31:16] : src2_q[15:0];
  assign tag_sel = (k_q == 2'd0) ? 2'd0 : ((k_q == 2'd3) ? 2'd2 : 2'd1);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.A_start) begin
          capture = 1'b1;
          state_d = S_ISSUE;
          k_d     = 2'd0;
        end
      end
      S_ISSUE: begin
        if (k_q == last_k) begin
          state_d = S_DRAIN;
          k_d     = 2'd0;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      // Two cycles: operand stage -> product stage -> accumulator.
      S_DRAIN: begin
        if (k_q == 2'd1) begin
          state_d = need_corr ? S_CORR : S_DONE;
          k_d     = 2'd0;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      S_CORR:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (capture) begin
      acc_d = 64'd0;
    end else if (prod_v_q) begin
      case (tag2_q)
        2'd0:    acc_d = acc_q + {32'd0, prod_q};
        2'd1:    acc_d = acc_q + {16'd0, prod_q, 16'd0};
        default: acc_d = acc_q + {prod_q, 32'd0};
      endcase
    end
`ifdef MULT_SEQ_SIGNED_EN
    if (state_q == S_CORR) begin
      acc_d[63:32] = acc_q[63:32]
                   - (src1_q[31] ? src2_q : 32'd0)
                   - ((op_q == 2'b01 && src2_q[31]) ? src1_q : 32'd0);
    end
`endif
  end

  always_comb begin
    result_d = result_q;
    if (state_d == S_DONE && state_q != S_DONE) begin
      result_d = (op_q == 2'b00) ? acc_d[31:0] : acc_d[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      k_q      <= 2'd0;
      op_q     <= 2'b00;
      src1_q   <= 32'd0;
      src2_q   <= 32'd0;
      mul_a_q  <= 16'd0;
      mul_b_q  <= 16'd0;
      tag1_q   <= 2'd0;
      tag2_q   <= 2'd0;
      iss_v_q  <= 1'b0;
      prod_v_q <= 1'b0;
      prod_q   <= 32'd0;
      acc_q    <= 64'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      if (capture) begin
        op_q   <= bus.A_op;
        src1_q <= bus.A_src1;
        src2_q <= bus.A_src2;
      end
      iss_v_q <= (state_q == S_ISSUE);
      if (state_q == S_ISSUE) begin
        mul_a_q <= a_sel;
        mul_b_q <= b_sel;
        tag1_q  <= tag_sel;
      end
      prod_v_q <= mult_en && iss_v_q;
      if (mult_en) begin
        prod_q <= mul_a_q * mul_b_q;
        tag2_q <= tag1_q;
      end
    end
  end

  assign bus.A_busy   = (state_q != S_IDLE);
  assign bus.A_done   = (state_q == S_DONE);
  assign bus.A_result = result_q;

endmodule

// File: tb/tb_niossys_mycpu_cpu_mult_seq.sv
// Directed bench for the sequential multiplier; expected values are hand-computed
// for both builds (with and without MULT_SEQ_SIGNED_EN).
`timescale 1ns/1ps
module tb_niossys_mycpu_cpu_mult_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  niossys_mycpu_cpu_mult_seq_if bus ();

  niossys_mycpu_cpu_mult_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

`ifdef MULT_SEQ_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif
  localparam int LAT_SIGNED = SIGNED_BUILD ? 7 : 6;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for A_done; returns the number of edges seen (starting from start_cyc).
  task automatic wait_done(input int start_cyc, output int cyc);
    cyc = start_cyc;
    while (!bus.A_done && cyc < 30) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cyc;
    bus.A_op    = op;
    bus.A_src1  = a;
    bus.A_src2  = b;
    bus.A_start = 1'b1;
    tick();
    bus.A_start = 1'b0;
    check_eq($sformatf("%s_busy", tag), {31'd0, bus.A_busy}, 32'd1);
    wait_done(0, cyc);
    check_eq($sformatf("%s_lat", tag), cyc, lat);
    check_eq($sformatf("%s_res", tag), bus.A_result, exp);
    $display("op=%0d a=0x%08h b=0x%08h -> result=0x%08h after %0d cycles", op, a, b, bus.A_result, cyc);
    tick();
    check_eq($sformatf("%s_done_pulse", tag), {31'd0, bus.A_done}, 32'd0);
    check_eq($sformatf("%s_idle", tag), {31'd0, bus.A_busy}, 32'd0);
    check_eq($sformatf("%s_hold", tag), bus.A_result, exp);
  endtask

  initial begin
    int cyc;
    int dones;

    bus.A_start = 1'b0;
    bus.A_op    = 2'b00;
    bus.A_src1  = 32'd0;
    bus.A_src2  = 32'd0;

    tick();
    tick();
    check_eq("rst_busy", {31'd0, bus.A_busy}, 32'd0);
    check_eq("rst_done", {31'd0, bus.A_done}, 32'd0);
    check_eq("rst_result", bus.A_result, 32'd0);
    reset_n = 1'b1;
    tick();

    run_op("mul_3x5",     2'b00, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 5);
    run_op("mulxuu_ff",   2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 6);
    run_op("mulxss_ff",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           SIGNED_BUILD ? 32'h0000_0000 : 32'hFFFF_FFFE, LAT_SIGNED);
    run_op("mulxss_min",  2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_SIGNED);
    run_op("mulxsu_ff",   2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           SIGNED_BUILD ? 32'hFFFF_FFFF : 32'hFFFF_FFFE, LAT_SIGNED);
    run_op("mulxss_m2x3", 2'b01, 32'hFFFF_FFFE, 32'h0000_0003,
           SIGNED_BUILD ? 32'hFFFF_FFFF : 32'h0000_0002, LAT_SIGNED);
    run_op("mulxsu_3xmsb", 2'b10, 32'h0000_0003, 32'h8000_0000, 32'h0000_0001, LAT_SIGNED);
    run_op("mul_cross",   2'b00, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 5);
    run_op("mulxuu_hihi", 2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 6);
    run_op("mul_ff",      2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 5);

    // Start pulse while busy must be dropped; operand changes must not leak in.
    bus.A_op    = 2'b11;
    bus.A_src1  = 32'h1234_5678;
    bus.A_src2  = 32'h9ABC_DEF0;
    bus.A_start = 1'b1;
    tick();
    bus.A_start = 1'b0;
    tick();
    bus.A_op    = 2'b00;
    bus.A_src1  = 32'h0000_0003;
    bus.A_src2  = 32'h0000_0005;
    bus.A_start = 1'b1;
    tick();
    bus.A_start = 1'b0;
    wait_done(2, cyc);
    check_eq("drop_lat", cyc, 6);
    check_eq("drop_res", bus.A_result, 32'h0B00_EA4E);
    $display("op=3 busy-start dropped -> result=0x%08h after %0d cycles", bus.A_result, cyc);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.A_done) dones++;
    end
    check_eq("drop_single_done", dones, 0);
    check_eq("drop_idle", {31'd0, bus.A_busy}, 32'd0);

    // Start held high through DONE: next op accepted on the following idle cycle.
    bus.A_op    = 2'b11;
    bus.A_src1  = 32'h1234_5678;
    bus.A_src2  = 32'h9ABC_DEF0;
    bus.A_start = 1'b1;
    tick();
    bus.A_op    = 2'b00;
    bus.A_src1  = 32'h0000_0003;
    bus.A_src2  = 32'h0000_0005;
    wait_done(0, cyc);
    check_eq("hold_lat1", cyc, 6);
    check_eq("hold_res1", bus.A_result, 32'h0B00_EA4E);
    tick();
    check_eq("hold_idle_gap", {31'd0, bus.A_busy}, 32'd0);
    tick();
    bus.A_start = 1'b0;
    check_eq("hold_accept", {31'd0, bus.A_busy}, 32'd1);
    wait_done(0, cyc);
    check_eq("hold_lat2", cyc, 5);
    check_eq("hold_res2", bus.A_result, 32'h0000_000F);
    $display("op=0 back-to-back after held start -> result=0x%08h after %0d cycles", bus.A_result, cyc);
    tick();

    // Reset mid-operation discards the in-flight result.
    bus.A_op    = 2'b01;
    bus.A_src1  = 32'hFFFF_FFFF;
    bus.A_src2  = 32'hFFFF_FFFF;
    bus.A_start = 1'b1;
    tick();
    bus.A_start = 1'b0;
    dones = 0;
    tick();
    if (bus.A_done) dones++;
    tick();
    if (bus.A_done) dones++;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_eq("abort_busy", {31'd0, bus.A_busy}, 32'd0);
    check_eq("abort_result", bus.A_result, 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (bus.A_done) dones++;
      tick();
    end
    check_eq("abort_no_done", dones, 0);
    $display("op=1 aborted by reset -> result=0x%08h", bus.A_result);
    run_op("mul_after_rst", 2'b00, 32'h0000_0002, 32'h0000_0007, 32'h0000_000E, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
